// File: rtl/ov5640_top.sv
// OV5640 camera-side control: XCLK generation, PWDN/RESETB power-up
// sequencing and a single-transaction SCCB master for 16-bit-address,
// 8-bit-data register writes and reads.
module ov5640_top #(
   parameter int CLK_FREQ = 50000000,
   parameter int SCL_FREQ = 100000,
   parameter int T_PWDN   = 50000,
   parameter int T_RST    = 50000,
   parameter int T_INIT   = 1000000
) (
   input  logic        clk_sys50m,
   input  logic        rst_n,
   input  logic        clk_sys24m,
   output logic        ov5640_pwdn,
   output logic        ov5640_rst_n,
   output logic        ov5640_xclk,
   output logic        ov5640_iic_scl,
   inout  wire         ov5640_iic_sda,
   input  logic        estart,
   input  logic [31:0] ewdata,
   output logic [7:0]  riic_data
);

   localparam int          Q             = CLK_FREQ / (4 * SCL_FREQ);
   localparam logic [15:0] LP_Q_LAST     = 16'(Q - 1);
   localparam logic [31:0] LP_PWDN_LAST  = 32'(T_PWDN - 1);
   localparam logic [31:0] LP_RST_LAST   = 32'(T_RST - 1);
   localparam logic [31:0] LP_INIT_LAST  = 32'(T_INIT - 1);

   typedef enum logic [1:0] {P_HI, P_RST, P_WAIT, P_READY} pwrState_t;
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_SEND_BYTE, S_ACK, S_STOP,
      S_GAP, S_RESTART, S_READ_BYTE, S_MNACK
   } sccbState_t;

   pwrState_t   r_pwrState;
   logic [31:0] r_pwrCnt;
   logic        r_pwdn;
   logic        r_camRstN;
   logic        r_xclk;

   sccbState_t  r_sccbState;
   logic [15:0] r_qCnt;
   logic [1:0]  r_phase;
   logic [2:0]  r_bitCnt;
   logic [1:0]  r_byteIdx;
   logic [31:0] r_cmd;
   logic [7:0]  r_txByte;
   logic [6:0]  r_rxByte;
   logic [7:0]  r_riicData;
   logic        r_scl;
   logic        r_sdaLow;
   logic        r_inPhase2;
   logic        r_nacked;
   logic        r_ackBit;

   logic        w_qDone;
   logic        w_sdaIn;
   logic        w_isRead;
   logic        w_pwrReady;
   logic [1:0]  w_lastIdx;
   logic [7:0]  w_idByte;
   logic [7:0]  w_nextTx;
   logic        w_unused;

   assign w_unused       = clk_sys24m;
   assign w_qDone        = (r_qCnt == LP_Q_LAST);
   assign w_sdaIn        = ov5640_iic_sda;
   assign w_isRead       = r_cmd[24];
   assign w_pwrReady     = (r_pwrState == P_READY);
   assign w_lastIdx      = w_isRead ? 2'd2 : 2'd3;
   assign w_idByte       = {r_cmd[31:25], r_inPhase2};

   assign ov5640_pwdn    = r_pwdn;
   assign ov5640_rst_n   = r_camRstN;
   assign ov5640_xclk    = r_xclk;
   assign ov5640_iic_scl = r_scl;
   assign ov5640_iic_sda = r_sdaLow ? 1'b0 : 1'bz;
   assign riic_data      = r_riicData;

   // Pick the byte that follows the one just acknowledged (address hi, address lo, data)
   always_comb begin
      w_nextTx = r_cmd[7:0];
      case (r_byteIdx)
         2'd0:    w_nextTx = r_cmd[23:16];
         2'd1:    w_nextTx = r_cmd[15:8];
         default: w_nextTx = r_cmd[7:0];
      endcase
   end

   // Sensor master clock runs at half the system clock once out of reset
   always_ff @(posedge clk_sys50m) begin
      if (rst_n) r_xclk <= 1'b0;
      else       r_xclk <= ~r_xclk;
   end

   // Power-up sequence: hold PWDN, then hold RESETB, then wait for sensor init
   always_ff @(posedge clk_sys50m) begin
      if (rst_n) begin
         r_pwrState <= P_HI;
         r_pwrCnt   <= '0;
         r_pwdn     <= 1'b1;
         r_camRstN  <= 1'b0;
      end else begin
         case (r_pwrState)
            P_HI: begin
               if (r_pwrCnt == LP_PWDN_LAST) begin
                  r_pwrCnt   <= '0;
                  r_pwdn     <= 1'b0;
                  r_pwrState <= P_RST;
               end else r_pwrCnt <= r_pwrCnt + 32'd1;
            end
            P_RST: begin
               if (r_pwrCnt == LP_RST_LAST) begin
                  r_pwrCnt   <= '0;
                  r_camRstN  <= 1'b1;
                  r_pwrState <= P_WAIT;
               end else r_pwrCnt <= r_pwrCnt + 32'd1;
            end
            P_WAIT: begin
               if (r_pwrCnt == LP_INIT_LAST) begin
                  r_pwrCnt   <= '0;
                  r_pwrState <= P_READY;
               end else r_pwrCnt <= r_pwrCnt + 32'd1;
            end
            P_READY: r_pwrCnt <= '0;
         endcase
      end
   end

   // SCCB master: every bit is four Q-cycle phases, SCL low in 0-1 and high in 2-3,
   // SDA driven at phase 0 entry and sampled at phase 3 entry
   always_ff @(posedge clk_sys50m) begin
      if (rst_n) begin
         r_sccbState <= S_IDLE;
         r_qCnt      <= '0;
         r_phase     <= '0;
         r_bitCnt    <= '0;
         r_byteIdx   <= '0;
         r_cmd       <= '0;
         r_txByte    <= '0;
         r_rxByte    <= '0;
         r_riicData  <= '0;
         r_scl       <= 1'b1;
         r_sdaLow    <= 1'b0;
         r_inPhase2  <= 1'b0;
         r_nacked    <= 1'b0;
         r_ackBit    <= 1'b0;
      end else begin
         if (r_sccbState == S_IDLE || w_qDone) r_qCnt <= '0;
         else                                  r_qCnt <= r_qCnt + 16'd1;
         if (w_qDone) r_phase <= r_phase + 2'd1;

         case (r_sccbState)
            S_IDLE: begin
               r_phase <= '0;
               r_scl   <= 1'b1;
               if (estart && w_pwrReady) begin
                  r_cmd       <= ewdata;
                  r_inPhase2  <= 1'b0;
                  r_nacked    <= 1'b0;
                  r_sdaLow    <= 1'b1;
                  r_sccbState <= S_START;
               end
            end
            S_START, S_RESTART: begin
               if (w_qDone) begin
                  r_phase     <= '0;
                  r_bitCnt    <= '0;
                  r_byteIdx   <= '0;
                  r_txByte    <= w_idByte;
                  r_scl       <= 1'b0;
                  r_sdaLow    <= ~w_idByte[7];
                  r_sccbState <= S_SEND_BYTE;
               end
            end
            S_SEND_BYTE: begin
               if (w_qDone) begin
                  if (r_phase == 2'd1) r_scl <= 1'b1;
                  else if (r_phase == 2'd3) begin
                     r_scl <= 1'b0;
                     if (r_bitCnt == 3'd7) begin
                        r_sdaLow    <= 1'b0;
                        r_sccbState <= S_ACK;
                     end else begin
                        r_bitCnt <= r_bitCnt + 3'd1;
                        r_txByte <= {r_txByte[6:0], 1'b0};
                        r_sdaLow <= ~r_txByte[6];
                     end
                  end
               end
            end
            S_ACK: begin
               if (w_qDone) begin
                  if (r_phase == 2'd1) r_scl <= 1'b1;
                  else if (r_phase == 2'd2) r_ackBit <= w_sdaIn;
                  else if (r_phase == 2'd3) begin
                     r_scl    <= 1'b0;
                     r_bitCnt <= '0;
                     if (r_ackBit) begin
                        r_nacked    <= 1'b1;
                        r_sdaLow    <= 1'b1;
                        r_sccbState <= S_STOP;
                     end else if (r_inPhase2) begin
                        r_sdaLow    <= 1'b0;
                        r_sccbState <= S_READ_BYTE;
                     end else if (r_byteIdx == w_lastIdx) begin
                        r_sdaLow    <= 1'b1;
                        r_sccbState <= S_STOP;
                     end else begin
                        r_byteIdx   <= r_byteIdx + 2'd1;
                        r_txByte    <= w_nextTx;
                        r_sdaLow    <= ~w_nextTx[7];
                        r_sccbState <= S_SEND_BYTE;
                     end
                  end
               end
            end
            S_READ_BYTE: begin
               if (w_qDone) begin
                  if (r_phase == 2'd1) r_scl <= 1'b1;
                  else if (r_phase == 2'd2) begin
                     r_rxByte <= {r_rxByte[5:0], w_sdaIn};
                     if (r_bitCnt == 3'd7) r_riicData <= {r_rxByte, w_sdaIn};
                  end else if (r_phase == 2'd3) begin
                     r_scl <= 1'b0;
                     if (r_bitCnt == 3'd7) r_sccbState <= S_MNACK;
                     else                  r_bitCnt    <= r_bitCnt + 3'd1;
                  end
               end
            end
            S_MNACK: begin
               if (w_qDone) begin
                  if (r_phase == 2'd1) r_scl <= 1'b1;
                  else if (r_phase == 2'd3) begin
                     r_scl       <= 1'b0;
                     r_sdaLow    <= 1'b1;
                     r_sccbState <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (w_qDone) begin
                  if (r_phase == 2'd1) r_scl <= 1'b1;
                  else if (r_phase == 2'd2) r_sdaLow <= 1'b0;
                  else if (r_phase == 2'd3) begin
                     if (w_isRead && !r_inPhase2 && !r_nacked) begin
                        r_inPhase2  <= 1'b1;
                        r_sccbState <= S_GAP;
                     end else r_sccbState <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (w_qDone && r_phase == 2'd3) begin
                  r_sdaLow    <= 1'b1;
                  r_sccbState <= S_RESTART;
               end
            end
            default: r_sccbState <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov5640_top.sv
// Directed bench for ov5640_top: power sequencing, XCLK, SCCB write, read,
// slave NACK with retry, and reset in the middle of a byte.
module tb_ov5640_top;

   localparam int Q = 5;

   logic        clk = 1'b0;
   logic        clk24 = 1'b0;
   logic        rstIn;
   logic        estart;
   logic [31:0] ewdata;
   wire         pwdn;
   wire         camRstN;
   wire         xclk;
   wire         sclBus;
   wire         sdaBus;
   wire [7:0]   riicData;

   int          testCount = 0;
   int          failCount = 0;

   logic        slaveLow = 1'b0;
   logic        nackDev = 1'b0;
   logic [7:0]  rdData = 8'h00;
   logic        sclPrev = 1'b1;
   logic        sdaPrev = 1'b1;
   logic        sclNow;
   logic        sdaNow;
   int          sBit = 0;
   int          sByte = 0;
   logic        sRead = 1'b0;
   logic        sDone = 1'b1;
   logic [7:0]  sShift = 8'h00;
   logic [7:0]  sTx = 8'h00;
   logic        mNack = 1'b0;
   int          startCount = 0;
   int          stopCount = 0;
   int          ackCount = 0;
   int          cycCount = 0;
   int          sclLastRise = 0;
   int          sclPrevRise = 0;
   logic [7:0]  rxBytes[$];

   int          startBase;
   int          stopBase;
   int          ackBase;
   int          rxBase;

   assign sdaBus = slaveLow ? 1'b0 : 1'bz;
   pullup (sdaBus);

   always #5 clk = ~clk;
   always #21 clk24 = ~clk24;

   ov5640_top #(
      .CLK_FREQ(50000000),
      .SCL_FREQ(2500000),
      .T_PWDN(10),
      .T_RST(10),
      .T_INIT(20)
   ) dut (
      .clk_sys50m(clk),
      .rst_n(rstIn),
      .clk_sys24m(clk24),
      .ov5640_pwdn(pwdn),
      .ov5640_rst_n(camRstN),
      .ov5640_xclk(xclk),
      .ov5640_iic_scl(sclBus),
      .ov5640_iic_sda(sdaBus),
      .estart(estart),
      .ewdata(ewdata),
      .riic_data(riicData)
   );

   // SCCB slave: decodes START/STOP and bits from bus levels sampled mid-cycle,
   // ACKs written bytes and serves rdData during reads
   always @(negedge clk) begin
      cycCount++;
      sclNow = sclBus;
      sdaNow = (sdaBus === 1'b0) ? 1'b0 : 1'b1;
      if (sclPrev && sclNow && sdaPrev && !sdaNow) begin
         startCount++;
         sBit = 0; sByte = 0; sRead = 1'b0; sDone = 1'b0; slaveLow = 1'b0;
      end else if (sclPrev && sclNow && !sdaPrev && sdaNow) begin
         stopCount++;
         sDone = 1'b1; slaveLow = 1'b0;
      end else if (!sclPrev && sclNow) begin
         sclPrevRise = sclLastRise;
         sclLastRise = cycCount;
         if (!sDone) begin
            if (sBit < 8) sShift = {sShift[6:0], sdaNow};
            else if (sBit == 8 && sRead && sByte >= 1) mNack = sdaNow;
            sBit++;
         end
      end else if (sclPrev && !sclNow && !sDone) begin
         if (sBit == 8) begin
            if (sRead && sByte >= 1) slaveLow = 1'b0;
            else begin
               rxBytes.push_back(sShift);
               if (sByte == 0) sRead = sShift[0];
               if (sByte == 0 && nackDev) slaveLow = 1'b0;
               else begin
                  slaveLow = 1'b1;
                  ackCount++;
               end
            end
         end else if (sBit == 9) begin
            sBit = 0;
            if (sRead && sByte >= 1) begin
               sDone = 1'b1;
               slaveLow = 1'b0;
            end else begin
               sByte++;
               if (sRead) begin
                  sTx = rdData;
                  slaveLow = ~sTx[7];
               end else slaveLow = 1'b0;
            end
         end else if (sRead && sByte >= 1 && sBit >= 1 && sBit <= 7) begin
            sTx = {sTx[6:0], 1'b0};
            slaveLow = ~sTx[7];
         end
      end
      sclPrev = sclNow;
      sdaPrev = sdaNow;
   end

   // Hard stop in case the directed sequence wedges
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic stepCycles(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] data);
      ewdata = data;
      estart = 1'b1;
      stepCycles(1);
      estart = 1'b0;
   endtask

   task automatic takeBaseline();
      startBase = startCount;
      stopBase  = stopCount;
      ackBase   = ackCount;
      rxBase    = rxBytes.size();
   endtask

   task automatic waitStops(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while ((stopCount - stopBase) < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'((stopCount - stopBase) >= target), 32'd1);
   endtask

   initial begin
      rstIn  = 1'b1;
      estart = 1'b0;
      ewdata = 32'h0;
      stepCycles(5);
      checkOutput("rstPwdn", {31'b0, pwdn}, 32'd1);
      checkOutput("rstCamRst", {31'b0, camRstN}, 32'd0);
      checkOutput("rstXclk", {31'b0, xclk}, 32'd0);
      checkOutput("rstScl", {31'b0, sclBus}, 32'd1);
      checkOutput("rstSda", {31'b0, sdaBus}, 32'd1);
      checkOutput("rstRiic", {24'b0, riicData}, 32'h00);

      rstIn = 1'b0;
      stepCycles(1);
      checkOutput("xclkHigh", {31'b0, xclk}, 32'd1);
      stepCycles(1);
      checkOutput("xclkLow", {31'b0, xclk}, 32'd0);
      stepCycles(7);
      checkOutput("pwdnCycle9", {31'b0, pwdn}, 32'd1);
      stepCycles(1);
      checkOutput("pwdnCycle10", {31'b0, pwdn}, 32'd0);
      checkOutput("camRstCycle10", {31'b0, camRstN}, 32'd0);
      stepCycles(9);
      checkOutput("camRstCycle19", {31'b0, camRstN}, 32'd0);
      stepCycles(1);
      checkOutput("camRstCycle20", {31'b0, camRstN}, 32'd1);

      takeBaseline();
      applyStimulus(32'h7830_0811);
      stepCycles(9);
      checkOutput("preReadyScl", {31'b0, sclBus}, 32'd1);
      checkOutput("preReadyStarts", 32'(startCount - startBase), 32'd0);
      stepCycles(10);

      takeBaseline();
      applyStimulus(32'h7830_0811);
      waitStops(1, 2000, "writeStop");
      stepCycles(Q + 2);
      checkOutput("writeNumBytes", 32'(rxBytes.size() - rxBase), 32'd4);
      checkOutput("writeByte0", {24'b0, rxBytes[rxBase]}, 32'h78);
      checkOutput("writeByte1", {24'b0, rxBytes[rxBase + 1]}, 32'h30);
      checkOutput("writeByte2", {24'b0, rxBytes[rxBase + 2]}, 32'h08);
      checkOutput("writeByte3", {24'b0, rxBytes[rxBase + 3]}, 32'h11);
      checkOutput("writeStarts", 32'(startCount - startBase), 32'd1);
      checkOutput("writeAcks", 32'(ackCount - ackBase), 32'd4);
      checkOutput("sclPeriod", 32'(sclLastRise - sclPrevRise), 32'(4 * Q));
      checkOutput("writeRiic", {24'b0, riicData}, 32'h00);

      takeBaseline();
      rdData = 8'h56;
      applyStimulus(32'h7930_0A00);
      waitStops(2, 4000, "readStops");
      stepCycles(Q + 2);
      checkOutput("readNumBytes", 32'(rxBytes.size() - rxBase), 32'd4);
      checkOutput("readByte0", {24'b0, rxBytes[rxBase]}, 32'h78);
      checkOutput("readByte1", {24'b0, rxBytes[rxBase + 1]}, 32'h30);
      checkOutput("readByte2", {24'b0, rxBytes[rxBase + 2]}, 32'h0A);
      checkOutput("readByte3", {24'b0, rxBytes[rxBase + 3]}, 32'h79);
      checkOutput("readStarts", 32'(startCount - startBase), 32'd2);
      checkOutput("readMasterNack", {31'b0, mNack}, 32'd1);
      checkOutput("readRiic", {24'b0, riicData}, 32'h56);

      takeBaseline();
      nackDev = 1'b1;
      applyStimulus(32'h7830_0811);
      waitStops(1, 1000, "nackStop");
      checkOutput("nackNumBytes", 32'(rxBytes.size() - rxBase), 32'd1);
      checkOutput("nackByte0", {24'b0, rxBytes[rxBase]}, 32'h78);
      checkOutput("nackAcks", 32'(ackCount - ackBase), 32'd0);
      checkOutput("nackRiicHeld", {24'b0, riicData}, 32'h56);

      nackDev = 1'b0;
      takeBaseline();
      ewdata = 32'h7812_3455;
      estart = 1'b1;
      begin
         int n;
         n = 0;
         while (startCount == startBase && n < Q + 6) begin
            @(negedge clk);
            n++;
         end
      end
      estart = 1'b0;
      checkOutput("retryAccepted", 32'(startCount - startBase), 32'd1);
      waitStops(1, 2000, "retryStop");
      stepCycles(Q + 2);
      checkOutput("retryNumBytes", 32'(rxBytes.size() - rxBase), 32'd4);
      checkOutput("retryByte1", {24'b0, rxBytes[rxBase + 1]}, 32'h12);
      checkOutput("retryByte2", {24'b0, rxBytes[rxBase + 2]}, 32'h34);
      checkOutput("retryByte3", {24'b0, rxBytes[rxBase + 3]}, 32'h55);

      applyStimulus(32'h7830_0811);
      stepCycles(30);
      rstIn = 1'b1;
      stepCycles(1);
      checkOutput("midRstScl", {31'b0, sclBus}, 32'd1);
      checkOutput("midRstSda", {31'b0, sdaBus}, 32'd1);
      checkOutput("midRstPwdn", {31'b0, pwdn}, 32'd1);
      checkOutput("midRstCamRst", {31'b0, camRstN}, 32'd0);
      checkOutput("midRstXclk", {31'b0, xclk}, 32'd0);
      rstIn = 1'b0;
      stepCycles(9);
      checkOutput("restartPwdn9", {31'b0, pwdn}, 32'd1);
      stepCycles(1);
      checkOutput("restartPwdn10", {31'b0, pwdn}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/ov5640_top.md
Name: ov5640_top

Overview:
Camera-side control block for an OV5640 sensor. It generates the sensor master clock (XCLK) and runs the power-up sequence on PWDN and RESETB. It also provides a single-transaction SCCB (I2C-compatible) master, so the host can write or read one 8-bit register at a 16-bit address. It sits between the system controller and the sensor pins, and is clocked from the 50 MHz system clock.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
SCL_FREQ, 100000, SCCB clock frequency in Hz; quarter-period Q = CLK_FREQ/(4*SCL_FREQ) = 125 cycles
T_PWDN, 50000, cycles PWDN is held high after reset (1 ms)
T_RST, 50000, cycles from PWDN low to sensor reset release (1 ms)
T_INIT, 1000000, cycles from reset release until SCCB is allowed (20 ms)

Ports:
clk_sys50m  input  1  sole clock, 50 MHz
rst_n  input  1  synchronous reset, active-high: rst_n=1 resets the block on the next clk_sys50m edge
clk_sys24m  input  1  unused; kept for board compatibility, may be left unconnected; no logic reads it
ov5640_pwdn  output  1  sensor power-down, active-high
ov5640_rst_n  output  1  sensor reset, active-low
ov5640_xclk  output  1  sensor master clock = clk_sys50m/2 (25 MHz)
ov5640_iic_scl  output  1  SCCB clock, push-pull, idle high
ov5640_iic_sda  inout  1  SCCB data, open-drain: driven 0 or Z; external pull-up
estart  input  1  one-cycle transaction request
ewdata  input  32  [31:25] 7-bit device id (OV5640 = 7'h3C), [24] 1=read / 0=write, [23:8] register address, [7:0] write data
riic_data  output  8  last byte read from the sensor

Behaviour:
- Reset values: ov5640_pwdn=1, ov5640_rst_n=0, ov5640_xclk=0, scl=1, sda=Z, riic_data=8'h00. All counters and FSMs are cleared; reset mid-transaction aborts immediately to these values.
- XCLK toggles every clk_sys50m cycle after reset deasserts.
- Power FSM states and transitions:
  - PWR_HI: T_PWDN cycles, then pwdn drops to 0.
  - PWR_RST: T_RST cycles, then ov5640_rst_n goes to 1.
  - PWR_WAIT: T_INIT cycles.
  - READY: terminal until reset.
- estart is ignored unless the power FSM is in READY and the SCCB FSM is IDLE. There is no queuing. ewdata is captured on the accepted estart cycle.
- SCCB timing: each bit is 4 phases of Q cycles.
  - SCL is low in phases 0-1 and high in phases 2-3.
  - SDA changes only at the start of phase 0.
  - SDA is sampled at the start of phase 3.
- Start condition: SDA falls while SCL is high, Q cycles before SCL falls.
- Stop condition: SCL rises, then after Q cycles SDA is released while SCL is high.
- Write transaction: START, {id,0}, ACK, addr[15:8], ACK, addr[7:0], ACK, data, ACK, STOP.
- Read transaction:
  - Phase 1: START, {id,0}, ACK, addr[15:8], ACK, addr[7:0], ACK, STOP.
  - Idle SCL/SDA high for 4Q cycles.
  - Phase 2: START, {id,1}, ACK, 8 data bits MSB-first, master NACK (SDA released), STOP.
- Bytes are sent MSB first. SDA is released (Z) during ACK slots.
- ACK handling: SDA sampled 1 in an ACK slot counts as a NACK. On NACK the FSM issues STOP and returns to IDLE; riic_data is unchanged.
- riic_data updates only after the 8th data bit of a successful read is sampled, and holds until the next successful read.
- SCCB FSM states: IDLE, START, SEND_BYTE, ACK, STOP, GAP, RESTART, READ_BYTE, MNACK.
- Back-to-back requests: an estart in the cycle the FSM returns to IDLE is accepted.

Test Plan:
- Assert rst_n=1 for 5 cycles, then deassert -> pwdn=1, ov5640_rst_n=0, scl=1, sda=Z; xclk toggles each cycle. With T_PWDN=10, T_RST=10, T_INIT=20 overridden: pwdn falls at cycle 10, ov5640_rst_n rises at cycle 20.
- Pulse estart before READY with ewdata=32'h7830_0811 -> no SCL activity; request dropped.
- After READY, write ewdata=32'h7830_0811 with a slave model that ACKs -> bus sees START, bytes 0x78, 0x30, 0x08, 0x11, STOP; 4 ACK slots; SCL period 4Q = 500 cycles; riic_data stays 0x00.
- Read ewdata=32'h7930_0A00 with the slave returning 0x56 -> bus sees 0x78, 0x30, 0x0A, STOP, then START, 0x79, read byte, NACK, STOP; riic_data=0x56 after the final data bit.
- Write with the slave NACKing the device byte -> STOP follows immediately; FSM returns to IDLE; a new estart is accepted.
- Assert rst_n mid-byte -> scl=1, sda=Z, pwdn=1 on the next edge; the power sequence restarts.
